// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage in front of the ALU.
//   - Default widths for operands and register numbers.
//   - ALU opcode encodings.
//   - Control record for the ID/EX slot, including the values that make up a bubble.
package alu_operand_stage_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluMul = 3'b011;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluNop = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [2:0] alu_control;
  } ex_ctrl_t;

  // An injected bubble must not write, must not load, and presents NOP to the ALU.
  localparam ex_ctrl_t BubbleCtrl = '{
    valid:       1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    alu_control: AluNop
  };

endpackage

// File: rtl/alu_fwd_mux.sv
// Forwarding select for one ALU operand.
//   src_i          captured source register number
//   reg_data_i     captured register-file value
//   exm_we_i / exm_dest_i / exm_result_i   EX/MEM writer
//   wb_we_i  / wb_dest_i  / wb_data_i      MEM/WB writer
//   data_o         forwarded operand
// EX/MEM beats MEM/WB (it is the younger result). Register 0 never matches, so it
// always yields the captured value.
module alu_fwd_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_we_i,
  input  logic [REG_AW-1:0] exm_dest_i,
  input  logic [DATA_W-1:0] exm_result_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic exm_hit;
  logic wb_hit;

  assign exm_hit = exm_we_i && (exm_dest_i != '0) && (exm_dest_i == src_i);
  assign wb_hit  = wb_we_i && (wb_dest_i != '0) && (wb_dest_i == src_i);

  always_comb begin
    data_o = reg_data_i;
    if (exm_hit) begin
      data_o = exm_result_i;
    end else if (wb_hit) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register directly upstream of the ALU.
// Captures decoded operands and control, detects hazards (stall + bubble), and
// presents DataA/DataB/ALU_control/hazard_hz to the ALU.
//   Inputs : clk, reset (async, active-high), id_* decode fields, flush,
//            exm_* (EX/MEM writer), wb_* (MEM/WB writer)
//   Outputs: stall (combinational), DataA, DataB, ALU_control, hazard_hz,
//            ex_valid, ex_dest, ex_RegWrite, ex_MemRead
// Build option: ALU_FORWARD_EN
//   defined   - operands forwarded from EX/MEM then MEM/WB; only load-use stalls.
//   undefined - no forwarding; any RAW against the ID/EX or EX/MEM writer stalls
//               until that writer is in writeback (register file is write-before-read).
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned REG_AW = RegAddrWidth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_ALUSrc,
  input  logic [2:0]        id_ALU_control,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              flush,
  input  logic              exm_RegWrite,
  input  logic [REG_AW-1:0] exm_dest,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_RegWrite,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic [2:0]        ALU_control,
  output logic              hazard_hz,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_RegWrite,
  output logic              ex_MemRead
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic              hz_q, hz_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              alusrc_q, alusrc_d;

  logic hazard;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
`ifdef ALU_FORWARD_EN
  // Only a load result is too late to forward.
  assign hazard = ctrl_q.valid && ctrl_q.mem_read && (dest_q != '0) && id_valid &&
                  ((dest_q == id_rs) || ((dest_q == id_rt) && !id_ALUSrc));
`else
  logic ex_raw;
  logic exm_raw;

  // rt only matters when it actually feeds operand B.
  assign ex_raw  = ctrl_q.valid && ctrl_q.reg_write && (dest_q != '0) &&
                   ((dest_q == id_rs) || ((dest_q == id_rt) && !id_ALUSrc));
  assign exm_raw = exm_RegWrite && (exm_dest != '0) &&
                   ((exm_dest == id_rs) || ((exm_dest == id_rt) && !id_ALUSrc));
  assign hazard  = id_valid && (ex_raw || exm_raw);
`endif

  // A flushed instruction is discarded anyway, so it must not freeze fetch.
  assign stall = hazard && !flush;

  // ---------------------------------------------------------------------------
  // Next state: flush > hazard bubble > capture
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = BubbleCtrl;
    hz_d      = 1'b0;
    dest_d    = '0;
    rs_d      = '0;
    rt_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    alusrc_d  = 1'b0;
    if (flush) begin
      ctrl_d = BubbleCtrl;
    end else if (hazard) begin
      ctrl_d = BubbleCtrl;
      hz_d   = 1'b1;
    end else begin
      ctrl_d.valid       = id_valid;
      ctrl_d.reg_write   = id_valid && id_RegWrite;
      ctrl_d.mem_read    = id_valid && id_MemRead;
      ctrl_d.alu_control = id_ALU_control;
      dest_d             = id_dest;
      rs_d               = id_rs;
      rt_d               = id_rt;
      rs_data_d          = id_rs_data;
      rt_data_d          = id_rt_data;
      imm_d              = id_imm;
      alusrc_d           = id_ALUSrc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      hz_q      <= 1'b0;
      dest_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      hz_q      <= hz_d;
      dest_q    <= dest_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alusrc_q  <= alusrc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand select
  // ---------------------------------------------------------------------------
`ifdef ALU_FORWARD_EN
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  alu_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .src_i        (rs_q),
    .reg_data_i   (rs_data_q),
    .exm_we_i     (exm_RegWrite),
    .exm_dest_i   (exm_dest),
    .exm_result_i (exm_result),
    .wb_we_i      (wb_RegWrite),
    .wb_dest_i    (wb_dest),
    .wb_data_i    (wb_data),
    .data_o       (fwd_a)
  );

  alu_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .src_i        (rt_q),
    .reg_data_i   (rt_data_q),
    .exm_we_i     (exm_RegWrite),
    .exm_dest_i   (exm_dest),
    .exm_result_i (exm_result),
    .wb_we_i      (wb_RegWrite),
    .wb_dest_i    (wb_dest),
    .wb_data_i    (wb_data),
    .data_o       (fwd_b)
  );

  assign DataA = fwd_a;
  // The immediate is never a forwarding target.
  assign DataB = alusrc_q ? imm_q : fwd_b;
`else
  logic unused_fwd;

  // Forwarding sources and captured register numbers have no consumer here.
  assign unused_fwd = ^{rs_q, rt_q, exm_result, wb_RegWrite, wb_dest, wb_data};

  assign DataA = rs_data_q;
  assign DataB = alusrc_q ? imm_q : rt_data_q;
`endif

  assign ALU_control = ctrl_q.alu_control;
  assign hazard_hz   = hz_q;
  assign ex_valid    = ctrl_q.valid;
  assign ex_dest     = dest_q;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemRead  = ctrl_q.mem_read;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow the ALU_FORWARD_EN build.
module tb_alu_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_ALUSrc, id_RegWrite, id_MemRead;
  logic [2:0]    id_ALU_control;
  logic          flush;
  logic          exm_RegWrite;
  logic [AW-1:0] exm_dest;
  logic [DW-1:0] exm_result;
  logic          wb_RegWrite;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic [DW-1:0] DataA, DataB;
  logic [2:0]    ALU_control;
  logic          hazard_hz, ex_valid, ex_RegWrite, ex_MemRead;
  logic [AW-1:0] ex_dest;

  int tests_run = 0;
  int tests_failed = 0;

  alu_operand_stage #(
    .DATA_W (DW),
    .REG_AW (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_ALUSrc      (id_ALUSrc),
    .id_ALU_control (id_ALU_control),
    .id_dest        (id_dest),
    .id_RegWrite    (id_RegWrite),
    .id_MemRead     (id_MemRead),
    .flush          (flush),
    .exm_RegWrite   (exm_RegWrite),
    .exm_dest       (exm_dest),
    .exm_result     (exm_result),
    .wb_RegWrite    (wb_RegWrite),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .stall          (stall),
    .DataA          (DataA),
    .DataB          (DataB),
    .ALU_control    (ALU_control),
    .hazard_hz      (hazard_hz),
    .ex_valid       (ex_valid),
    .ex_dest        (ex_dest),
    .ex_RegWrite    (ex_RegWrite),
    .ex_MemRead     (ex_MemRead)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                        input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                        input logic src, input logic [DW-1:0] imm, input logic [2:0] op,
                        input logic [AW-1:0] dst, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_ALUSrc = src; id_imm = imm; id_ALU_control = op; id_dest = dst;
    id_RegWrite = rw; id_MemRead = mr;
  endtask

  task automatic set_exm(input logic we, input logic [AW-1:0] d, input logic [DW-1:0] r);
    exm_RegWrite = we; exm_dest = d; exm_result = r;
  endtask

  task automatic set_wb(input logic we, input logic [AW-1:0] d, input logic [DW-1:0] r);
    wb_RegWrite = we; wb_dest = d; wb_data = r;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0);
    set_exm(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    #12;
    check_eq("rst_DataA", DataA, 32'h0);
    check_eq("rst_DataB", DataB, 32'h0);
    check_eq("rst_ALU_control", {29'h0, ALU_control}, 32'h0);
    check_eq("rst_ctrl", {28'h0, ex_valid, ex_RegWrite, ex_MemRead, hazard_hz}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    reset = 1'b0;

    // add r3,r1,r2 with r1=5, r2=7
    set_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 3'b010, 5'd3, 1'b1, 1'b0);
    tick();
    check_eq("add_DataA", DataA, 32'd5);
    check_eq("add_DataB", DataB, 32'd7);
    check_eq("add_ALU_control", {29'h0, ALU_control}, 32'd2);
    check_eq("add_ex_dest", {27'h0, ex_dest}, 32'd3);

    // sub r4,r3,r1 ; register file still has stale r3=0
    set_id(1'b1, 5'd3, 32'd0, 5'd1, 32'd5, 1'b0, 32'h0, 3'b110, 5'd4, 1'b1, 1'b0);
`ifdef ALU_FORWARD_EN
    #1;
    check_eq("sub_no_stall", {31'h0, stall}, 32'h0);
    tick();
    set_exm(1'b1, 5'd3, 32'd12);
    #1;
    check_eq("sub_fwd_DataA", DataA, 32'd12);
    check_eq("sub_DataB", DataB, 32'd5);
    check_eq("sub_ALU_control", {29'h0, ALU_control}, 32'd6);
    set_exm(1'b0, 5'd0, 32'h0);

    // lw r8 then add r9,r8,r2: one bubble, then forward from MEM/WB
    set_id(1'b1, 5'd1, 32'd5, 5'd0, 32'd0, 1'b1, 32'd4, 3'b010, 5'd8, 1'b1, 1'b1);
    tick();
    check_eq("lw_ex_MemRead", {31'h0, ex_MemRead}, 32'd1);
    set_id(1'b1, 5'd8, 32'd0, 5'd2, 32'd7, 1'b0, 32'h0, 3'b010, 5'd9, 1'b1, 1'b0);
    #1;
    check_eq("lu_stall", {31'h0, stall}, 32'd1);
    tick();
    set_exm(1'b1, 5'd8, 32'h100);
    #1;
    check_eq("lu_bubble_hz", {31'h0, hazard_hz}, 32'd1);
    check_eq("lu_bubble_op", {29'h0, ALU_control}, 32'd7);
    check_eq("lu_bubble_valid", {31'h0, ex_valid}, 32'd0);
    check_eq("lu_stall_drop", {31'h0, stall}, 32'd0);
    tick();
    set_exm(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd8, 32'hDEAD);
    #1;
    check_eq("lu_issue_DataA", DataA, 32'hDEAD);
    check_eq("lu_issue_DataB", DataB, 32'd7);
    check_eq("lu_issue_hz", {31'h0, hazard_hz}, 32'd0);
    check_eq("lu_issue_valid", {31'h0, ex_valid}, 32'd1);
    set_wb(1'b0, 5'd0, 32'h0);

    // EX/MEM beats MEM/WB on r6
    set_id(1'b1, 5'd6, 32'd0, 5'd0, 32'd0, 1'b0, 32'h0, 3'b001, 5'd10, 1'b1, 1'b0);
    tick();
    set_exm(1'b1, 5'd6, 32'h10);
    set_wb(1'b1, 5'd6, 32'h20);
    #1;
    check_eq("prio_exm", DataA, 32'h10);
    set_exm(1'b0, 5'd6, 32'h10);
    #1;
    check_eq("prio_wb", DataA, 32'h20);
    set_exm(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
`else
    #1;
    check_eq("raw_ex_stall", {31'h0, stall}, 32'd1);
    tick();
    check_eq("raw_bubble_hz", {31'h0, hazard_hz}, 32'd1);
    check_eq("raw_bubble_op", {29'h0, ALU_control}, 32'd7);
    set_exm(1'b1, 5'd3, 32'd12);
    #1;
    check_eq("raw_exm_stall", {31'h0, stall}, 32'd1);
    tick();
    check_eq("raw_bubble2_hz", {31'h0, hazard_hz}, 32'd1);
    set_exm(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd3, 32'd12);
    id_rs_data = 32'd12;
    #1;
    check_eq("raw_wb_no_stall", {31'h0, stall}, 32'd0);
    tick();
    check_eq("raw_issue_DataA", DataA, 32'd12);
    check_eq("raw_issue_DataB", DataB, 32'd5);
    check_eq("raw_issue_hz", {31'h0, hazard_hz}, 32'd0);
    set_wb(1'b0, 5'd0, 32'h0);
`endif

    // Writer targets r0: no stall, reader keeps captured 0
    set_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 3'b010, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'h0, 3'b010, 5'd11, 1'b1, 1'b0);
    set_exm(1'b1, 5'd0, 32'hFFFF);
    #1;
    check_eq("r0_no_stall", {31'h0, stall}, 32'd0);
    tick();
    check_eq("r0_DataA", DataA, 32'h0);
    set_exm(1'b0, 5'd0, 32'h0);

    // flush and load-use together
    set_id(1'b1, 5'd1, 32'd5, 5'd0, 32'd0, 1'b1, 32'd8, 3'b010, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 32'd0, 5'd2, 32'd7, 1'b0, 32'h0, 3'b000, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check_eq("flush_stall", {31'h0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    check_eq("flush_hz", {31'h0, hazard_hz}, 32'd0);
    check_eq("flush_op", {29'h0, ALU_control}, 32'd7);
    check_eq("flush_valid", {31'h0, ex_valid}, 32'd0);

    // Immediate operand while rt matches a load in EX and the EX/MEM writer
    set_id(1'b1, 5'd1, 32'd5, 5'd0, 32'd0, 1'b1, 32'd0, 3'b010, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 32'd5, 5'd7, 32'd0, 1'b1, 32'hFFFFFFFC, 3'b010, 5'd13, 1'b1, 1'b0);
    set_exm(1'b1, 5'd7, 32'h55);
    #1;
    check_eq("imm_no_stall", {31'h0, stall}, 32'd0);
    tick();
    check_eq("imm_DataB", DataB, 32'hFFFFFFFC);
    check_eq("imm_DataA", DataA, 32'd5);
    set_exm(1'b0, 5'd0, 32'h0);

    // Asynchronous reset in the middle of a stall
    set_id(1'b1, 5'd1, 32'd5, 5'd0, 32'd0, 1'b1, 32'd0, 3'b010, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 32'd0, 5'd2, 32'd7, 1'b0, 32'h0, 3'b011, 5'd14, 1'b1, 1'b0);
    #1;
    check_eq("mid_stall", {31'h0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("arst_stall", {31'h0, stall}, 32'd0);
    check_eq("arst_ctrl", {28'h0, ex_valid, ex_RegWrite, ex_MemRead, hazard_hz}, 32'h0);
    check_eq("arst_DataA", DataA, 32'h0);
    check_eq("arst_op", {29'h0, ALU_control}, 32'h0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
